// File: rtl/ck_gate_ctrl.sv
// ck_gate_ctrl: main/DMP clock-gating controller with entry hysteresis and gated-cycle statistics
module ck_gate_ctrl #(
    parameter int SLEEP_DLY = 4,
    parameter int DMP_DLY   = 8,
    parameter int STAT_W    = 16
) (
    input  logic              clk_ungated,
    input  logic              rst_a,
    input  logic              ck_gating_en,
    input  logic              halt_r,
    input  logic              sleeping_r,
    input  logic              ld_pending,
    input  logic              mem_busy,
    input  logic              host_access,
    input  logic              irq_pending,
    input  logic              dmp_busy,
    input  logic              dmp_req,
    input  logic              stat_clr,
    output logic              ck_disable,
    output logic              ck_dmp_gated,
    output logic [1:0]        ck_state,
    output logic [STAT_W-1:0] gated_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        GATED = 2'b10
    } state_t;

    localparam logic [3:0] SLEEP_LAST = 4'(SLEEP_DLY - 1);
    localparam logic [3:0] DMP_LAST   = 4'(DMP_DLY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        dmp_cnt_q, dmp_cnt_d;
    logic              ck_disable_q, ck_disable_d;
    logic              ck_dmp_gated_q, ck_dmp_gated_d;
    logic [STAT_W-1:0] gated_cycles_q, gated_cycles_d;
    logic              idle, dmp_idle;

    // Idle conditions; a disabled gating option is simply never idle, which forces everything on
    always_comb begin
        idle     = ck_gating_en & (halt_r | sleeping_r) & ~ld_pending & ~mem_busy
                   & ~host_access & ~irq_pending;
        dmp_idle = ck_gating_en & ~dmp_busy & ~dmp_req;
    end

    // Main FSM next state: count consecutive idle cycles, gate after SLEEP_DLY, any wake returns to RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (idle) begin
                    state_d = (SLEEP_DLY == 1) ? GATED : DRAIN;
                    cnt_d   = (SLEEP_DLY == 1) ? 4'd0 : 4'd1;
                end
            end
            DRAIN: begin
                if (!idle) begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end else if (cnt_q == SLEEP_LAST) begin
                    state_d = GATED;
                end else begin
                    cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                end
            end
            GATED: begin
                if (!idle) begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
        ck_disable_d = (state_d == GATED);
    end

    // DMP gating: independent idle counter, gate after DMP_DLY consecutive idle cycles
    always_comb begin
        dmp_cnt_d      = !dmp_idle ? 4'd0
                       : (dmp_cnt_q == DMP_LAST || dmp_cnt_q == 4'hF) ? dmp_cnt_q
                       : dmp_cnt_q + 4'd1;
        ck_dmp_gated_d = !dmp_idle ? 1'b0
                       : (dmp_cnt_q == DMP_LAST) ? 1'b1
                       : ck_dmp_gated_q;
    end

    // Statistics: count cycles spent gated, saturating; clear has priority
    always_comb begin
        gated_cycles_d = stat_clr ? '0
                       : (ck_disable_q && !(&gated_cycles_q)) ? gated_cycles_q + 1'b1
                       : gated_cycles_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_ungated) begin
        if (rst_a) begin
            state_q        <= RUN;
            cnt_q          <= 4'd0;
            dmp_cnt_q      <= 4'd0;
            ck_disable_q   <= 1'b0;
            ck_dmp_gated_q <= 1'b0;
            gated_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dmp_cnt_q      <= dmp_cnt_d;
            ck_disable_q   <= ck_disable_d;
            ck_dmp_gated_q <= ck_dmp_gated_d;
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign ck_disable   = ck_disable_q;
    assign ck_dmp_gated = ck_dmp_gated_q;
    assign ck_state     = state_q;
    assign gated_cycles = gated_cycles_q;

endmodule

// File: tb/tb_ck_gate_ctrl.sv
// tb_ck_gate_ctrl: vector table, corner sequences and randomized run against a run-length reference model
module tb_ck_gate_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, halt, slp, ld, mem, host, irq, dbusy, dreq, clr;
    logic dis1, dmp1, dis2, dmp2;
    logic [1:0] st1, st2;
    logic [15:0] gc1;
    logic [3:0] gc2;

    int checks = 0;
    int failures = 0;

    ck_gate_ctrl #(.SLEEP_DLY(4), .DMP_DLY(8), .STAT_W(16)) u_dut (
        .clk_ungated(clk), .rst_a(rst), .ck_gating_en(en), .halt_r(halt), .sleeping_r(slp),
        .ld_pending(ld), .mem_busy(mem), .host_access(host), .irq_pending(irq),
        .dmp_busy(dbusy), .dmp_req(dreq), .stat_clr(clr),
        .ck_disable(dis1), .ck_dmp_gated(dmp1), .ck_state(st1), .gated_cycles(gc1)
    );

    ck_gate_ctrl #(.SLEEP_DLY(1), .DMP_DLY(1), .STAT_W(4)) u_min (
        .clk_ungated(clk), .rst_a(rst), .ck_gating_en(en), .halt_r(halt), .sleeping_r(slp),
        .ld_pending(ld), .mem_busy(mem), .host_access(host), .irq_pending(irq),
        .dmp_busy(dbusy), .dmp_req(dreq), .stat_clr(clr),
        .ck_disable(dis2), .ck_dmp_gated(dmp2), .ck_state(st2), .gated_cycles(gc2)
    );

    // Reference model: lengths of the current idle runs decide everything
    int m_run = 0, m_drun = 0, m_stat1 = 0, m_stat2 = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_drun = 0; m_stat1 = 0; m_stat2 = 0;
        end else begin
            m_stat1 = clr ? 0 : (m_run >= 4 && m_stat1 < 65535) ? m_stat1 + 1 : m_stat1;
            m_stat2 = clr ? 0 : (m_run >= 1 && m_stat2 < 15) ? m_stat2 + 1 : m_stat2;
            m_run  = (en && (halt || slp) && !ld && !mem && !host && !irq) ? (m_run < 1000 ? m_run + 1 : m_run) : 0;
            m_drun = (en && !dbusy && !dreq) ? (m_drun < 1000 ? m_drun + 1 : m_drun) : 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("dis", int'(dis1), int'(m_run >= 4));
        chk("state", int'(st1), m_run == 0 ? 0 : (m_run < 4 ? 1 : 2));
        chk("dmp", int'(dmp1), int'(m_drun >= 8));
        chk("stat", int'(gc1), m_stat1);
        chk("min_dis", int'(dis2), int'(m_run >= 1));
        chk("min_state", int'(st2), m_run == 0 ? 0 : 2);
        chk("min_dmp", int'(dmp2), int'(m_drun >= 1));
        chk("min_stat", int'(gc2), m_stat2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic quiet();
        rst = 0; en = 1; halt = 0; slp = 0; ld = 0; mem = 0; host = 0;
        irq = 0; dbusy = 0; dreq = 0; clr = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        tick();
        rst = 0;
    endtask

    typedef struct {
        logic r, e, h, i, q, c;
        logic [1:0] st;
        logic dis, dmp;
        int gc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 1, 1, 0, 0, 0, 2'd0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 0, 2'd1, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0, 0, 2'd1, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 0, 2'd1, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 0, 0, 2'd2, 1, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 0, 0, 2'd2, 1, 0, 1};
        tbl[6]  = '{0, 1, 1, 1, 0, 0, 2'd0, 0, 0, 2};
        tbl[7]  = '{0, 1, 1, 0, 0, 0, 2'd1, 0, 0, 2};
        tbl[8]  = '{0, 1, 1, 0, 1, 0, 2'd1, 0, 0, 2};
        tbl[9]  = '{0, 1, 1, 0, 0, 0, 2'd1, 0, 0, 2};
        tbl[10] = '{0, 1, 1, 0, 0, 0, 2'd2, 1, 0, 2};
        tbl[11] = '{0, 1, 1, 0, 0, 1, 2'd2, 1, 0, 0};
        tbl[12] = '{0, 1, 1, 0, 0, 0, 2'd2, 1, 0, 1};
        tbl[13] = '{0, 0, 1, 0, 0, 0, 2'd0, 0, 0, 2};

        quiet();
        for (int k = 0; k < 14; k++) begin
            rst = tbl[k].r; en = tbl[k].e; halt = tbl[k].h; irq = tbl[k].i;
            dreq = tbl[k].q; clr = tbl[k].c;
            tick();
            chk("tbl_state", int'(st1), int'(tbl[k].st));
            chk("tbl_dis", int'(dis1), int'(tbl[k].dis));
            chk("tbl_dmp", int'(dmp1), int'(tbl[k].dmp));
            chk("tbl_stat", int'(gc1), tbl[k].gc);
        end

        // Three idle cycles then a memory transaction: never gates
        do_reset();
        halt = 1;
        for (int k = 0; k < 3; k++) tick();
        chk("drain_state", int'(st1), 1);
        mem = 1;
        tick();
        chk("abort_state", int'(st1), 0);
        chk("abort_dis", int'(dis1), 0);
        mem = 0; halt = 0;

        // DMP gate rises exactly at the 8th idle edge
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("dmp_rise", int'(dmp1), int'(k == 8));
        end
        dreq = 1;
        tick();
        chk("dmp_req_clear", int'(dmp1), 0);
        dreq = 0;

        // dmp_req on the 8th edge keeps the gate open
        do_reset();
        for (int k = 0; k < 7; k++) tick();
        dreq = 1;
        tick();
        chk("dmp_req_last", int'(dmp1), 0);
        dreq = 0;

        // 20 gated cycles, clear, resume; then reset while fully gated
        do_reset();
        halt = 1;
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 20; k++) tick();
        chk("stat_20", int'(gc1), 20);
        chk("min_sat", int'(gc2), 15);
        clr = 1;
        tick();
        chk("stat_clr", int'(gc1), 0);
        clr = 0;
        tick();
        chk("stat_resume", int'(gc1), 1);
        chk("dmp_before_rst", int'(dmp1), 1);
        rst = 1;
        tick();
        chk("rst_dis", int'(dis1), 0);
        chk("rst_dmp", int'(dmp1), 0);
        chk("rst_state", int'(st1), 0);
        rst = 0;

        // Dropping the enable while gated forces everything on
        for (int k = 0; k < 10; k++) tick();
        chk("pre_en_dis", int'(dis1), 1);
        en = 0;
        tick();
        chk("en_off_dis", int'(dis1), 0);
        chk("en_off_dmp", int'(dmp1), 0);
        chk("en_off_state", int'(st1), 0);

        // Randomized traffic with long idle stretches
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst   = ($urandom_range(199) == 0);
            en    = ($urandom_range(49) != 0);
            halt  = ($urandom_range(9) < 7);
            slp   = ($urandom_range(9) < 2);
            ld    = ($urandom_range(29) == 0);
            mem   = ($urandom_range(19) == 0);
            host  = ($urandom_range(39) == 0);
            irq   = ($urandom_range(29) == 0);
            dbusy = ($urandom_range(9) == 0);
            dreq  = ($urandom_range(19) == 0);
            clr   = ($urandom_range(99) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ck_gate_ctrl.md
Name: ck_gate_ctrl

Overview:
- Clock-gating controller for the ARC600 core, clocked by the ungated core clock.
- Decides when the main clock and the DMP clock are switched off, and drives ck_disable and ck_dmp_gated into the clock generation module. That module latches the enables during the low clock phase and ANDs them with clk_in.
- Adds entry hysteresis and a saturating gated-cycle statistics counter for power profiling.

Parameters:
- SLEEP_DLY, 4: consecutive idle cycles required before ck_disable asserts; legal range 1..15.
- DMP_DLY, 8: consecutive DMP-idle cycles required before ck_dmp_gated asserts; legal range 1..15.
- STAT_W, 16: width of the gated-cycle statistics counter.

Ports:
- clk_ungated, in, 1: ungated core clock; the only clock.
- rst_a, in, 1: reset, synchronous, active-high.
- ck_gating_en, in, 1: clock-gating option enable; 0 forces all clocks on.
- halt_r, in, 1: ARC halted.
- sleeping_r, in, 1: ARC executing SLEEP.
- ld_pending, in, 1: outstanding load in the scoreboard.
- mem_busy, in, 1: main memory interface transaction in flight.
- host_access, in, 1: host/debug port access in progress.
- irq_pending, in, 1: any interrupt request asserted at int_unit.
- dmp_busy, in, 1: DMP pipeline holds an operation.
- dmp_req, in, 1: new DMP request presented this cycle.
- stat_clr, in, 1: clear the statistics counter.
- ck_disable, out, 1: registered; 1 = main, DMP and debug-gated domains off.
- ck_dmp_gated, out, 1: registered; 1 = DMP clock off.
- ck_state, out, 2: current FSM state (00 RUN, 01 DRAIN, 10 GATED).
- gated_cycles, out, STAT_W: saturating count of cycles with ck_disable=1.

Behaviour:
- Terms:
  - idle = ck_gating_en & (halt_r | sleeping_r) & ~ld_pending & ~mem_busy & ~host_access & ~irq_pending.
  - wake = ~idle.
- All outputs are registered on the rising edge of clk_ungated; there is no combinational input-to-output path.
- Reset (rst_a=1 at an edge): state=RUN, cnt=0, dmp_cnt=0, ck_disable=0, ck_dmp_gated=0, gated_cycles=0. Reset from GATED clears ck_disable at that same edge.
- Main FSM; ck_disable=1 only in GATED:
  - RUN: if idle, then go to GATED when SLEEP_DLY=1, otherwise go to DRAIN with cnt=1. Else stay in RUN.
  - DRAIN: if wake, go to RUN with cnt=0. Else if cnt==SLEEP_DLY-1, go to GATED. Else cnt+1.
  - GATED: if wake, go to RUN with cnt=0, so ck_disable is 0 after the next edge (1-cycle wake latency). Else stay in GATED.
  - Net timing: ck_disable rises at the edge that samples the SLEEP_DLY-th consecutive idle cycle.
  - Wake and the final DRAIN count on the same edge: wake wins, go to RUN.
- DMP gating:
  - dmp_idle = ck_gating_en & ~dmp_busy & ~dmp_req.
  - If ~dmp_idle: dmp_cnt=0 and ck_dmp_gated=0 at the next edge.
  - Else if dmp_cnt==DMP_DLY-1: ck_dmp_gated=1 and dmp_cnt holds.
  - Else dmp_cnt+1.
  - Net timing: ck_dmp_gated rises at the edge sampling the DMP_DLY-th consecutive dmp_idle cycle.
  - dmp_req on that same edge wins: ck_dmp_gated stays 0.
  - ck_dmp_gated is independent of the main FSM; ck_gen already ANDs it with ck_enable.
- ck_gating_en=0 at any edge: next state RUN, cnt=0, dmp_cnt=0, both gating outputs 0.
- Statistics counter:
  - gated_cycles increments by 1 on each edge where the registered ck_disable is 1, saturating at all-ones.
  - stat_clr=1 sets it to 0; stat_clr has priority over increment.
- Counters cnt and dmp_cnt are 4 bits and never wrap: they hold at the terminal value.

Test Plan:
- Reset, ck_gating_en=1, halt_r=1, all others 0, SLEEP_DLY=4: ck_disable=0 for 3 edges, rises at the 4th edge, ck_state=10.
- In GATED, pulse irq_pending for 1 cycle: ck_disable=0 after the next edge, state RUN. With halt_r still 1 it re-enters GATED 4 edges later.
- halt_r=1 for 3 cycles, then mem_busy=1 on the 4th: ck_disable never asserts, FSM returns to RUN with cnt=0.
- DMP_DLY=8, dmp_busy=0, dmp_req=0: ck_dmp_gated rises at the 8th edge. A dmp_req on the 8th edge keeps it 0. dmp_req while gated clears it after the next edge.
- Hold GATED for 20 cycles, then stat_clr=1 together with continued gating: gated_cycles reads 20, then 0, then resumes counting. Force gated_cycles to 0xFFFF: it stays 0xFFFF.
- rst_a=1 while GATED with ck_dmp_gated=1, or ck_gating_en dropped while GATED: both outputs 0 after that edge, ck_state=00.
